// File: rtl/sync_fifo_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog_if
// Purpose  : Handshake/status bundle between a stream client and the
//            sync_fifo_prog FIFO (single clock domain).
// Signals  : wr_en, data_in, rd_en            - client -> FIFO
//            data_out, rd_valid, wr_ack,
//            overflow, underflow, full, empty,
//            almostfull, almostempty, count    - FIFO -> client
//            flush                             - client -> FIFO, only when
//                                                SYNC_FIFO_FLUSH_EN is defined
// Modports : master (client side), slave (FIFO side)
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_prog_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [c_CW-1:0]       count;
`ifdef SYNC_FIFO_FLUSH_EN
    logic                  flush;
`endif

    modport master (
        output wr_en, data_in, rd_en,
`ifdef SYNC_FIFO_FLUSH_EN
        output flush,
`endif
        input  data_out, rd_valid, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, data_in, rd_en,
`ifdef SYNC_FIFO_FLUSH_EN
        input  flush,
`endif
        output data_out, rd_valid, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Purpose  : Single-clock FIFO with arbitrary (non power-of-two) depth,
//            programmable almost-full/almost-empty thresholds, optional
//            first-word-fall-through read, occupancy count, and correct
//            simultaneous read/write at the full and empty boundaries.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - sync_fifo_prog_if.slave (write/read handshake, data,
//                   ack/overflow/underflow pulses, status flags, count)
// Options  : SYNC_FIFO_FLUSH_EN - adds bus.flush, a synchronous clear of
//            pointers and count that leaves the memory and (standard mode)
//            data_out untouched.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sync_fifo_prog_if.slave  bus
);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_PW-1:0]       w_wr_ptr_nxt;
    logic [c_PW-1:0]       w_rd_ptr_nxt;
    logic [c_CW-1:0]       r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_flush;

`ifdef SYNC_FIFO_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same cycle, so a write is still accepted
    // when full if a read is accepted alongside it. Flush overrides both.
    assign w_rd_acc = bus.rd_en && !w_empty && !w_flush;
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc) && !w_flush;

    // Explicit wrap so any depth works, not just powers of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= bus.wr_en && !w_wr_acc;
            r_underflow <= bus.rd_en && !w_rd_acc;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) r_mem[r_wr_ptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; a write into an empty
            // FIFO shows up once count has stepped to 1.
            assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
            assign bus.rd_valid = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign bus.data_out = r_data_out;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count >= c_CW'(AF_THRESH));
    assign bus.almostempty = (r_count <= c_CW'(AE_THRESH));
    assign bus.count       = r_count;
endmodule
`default_nettype wire
